seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 108 ++++++++++
 tb/tb_seq_multiplier.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_multiplier                                                    |
// | Purpose : radix-2 shift-add multiplier, one multiplier bit per cycle,        |
// |           signed or unsigned operands, IDLE/CALC/DONE control.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_next;

   logic [PW-1:0]    mcand;
   logic [WIDTH-1:0] mplier;
   logic [PW-1:0]    acc;
   logic [CW-1:0]    cnt;
   logic             neg;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [PW-1:0]    acc_sum;
   logic             last_bit;

   // The most negative operand maps to 2^(W-1), which still fits as an unsigned magnitude.
   assign a_mag    = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign b_mag    = (signed_mode && b[WIDTH-1]) ? -b : b;
   assign acc_sum  = acc + (mplier[0] ? mcand : {PW{1'b0}});
   assign last_bit = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = S_IDLE;
      case (state)
         S_IDLE:  state_next = start    ? S_CALC : S_IDLE;
         S_CALC:  state_next = last_bit ? S_DONE : S_CALC;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_CALC);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         p      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, a_mag};
                  mplier <= b_mag;
                  acc    <= '0;
                  cnt    <= '0;
                  neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               end
            end
            S_CALC: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               // Result is taken from the final partial sum so DONE presents it directly.
               if (last_bit) begin
                  p <= neg ? -acc_sum : acc_sum;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seq_multiplier                                                 |
// | Purpose : directed and random stimulus against an arithmetic reference.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seq_multiplier;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          signed_mode = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy;
   logic          done;
   logic [2*W-1:0] p;

   int checks = 0;
   int errors = 0;

   seq_multiplier #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .p           (p)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic sm);
      longint xv;
      longint yv;
      logic [63:0] prod;
      xv = longint'(x);
      yv = longint'(y);
      if (sm && x[W-1]) xv = xv - (longint'(1) << W);
      if (sm && y[W-1]) yv = yv - (longint'(1) << W);
      prod = 64'(xv * yv);
      return prod[2*W-1:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: an accepted request produces W busy cycles then one done cycle.
   int             left = 0;
   logic [2*W-1:0] pend = '0;
   logic [2*W-1:0] exp_p = '0;
   logic           chk_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         left  = 0;
         exp_p = '0;
      end else if (left == 0) begin
         if (start) begin
            left = W + 1;
            pend = ref_mul(a, b, signed_mode);
         end
      end else begin
         left = left - 1;
         if (left == 1) exp_p = pend;
      end
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 64'(busy), 64'(left > 1));
         chk("done", 64'(done), 64'(left == 1));
         chk("p", 64'(p), 64'(exp_p));
         chk("busy_and_done", 64'(busy & done), 64'd0);
      end
   end

   // Drives a request, then counts edges from the edge preceding the drive until done.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic sm,
                         input logic [2*W-1:0] exp_lit, input string name);
      int k;
      @(negedge clk);
      a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
      k = 1;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_latency"}, 64'(k), 64'd9);
      chk({name, "_p"}, 64'(p), 64'(exp_lit));
   endtask

   initial begin
      int k;
      int nbusy;
      int last_d;
      int ndone;

      repeat (3) @(negedge clk);
      chk("reset_p", 64'(p), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      rst = 1'b0;

      run_op(8'd1, 8'd3, 1'b0, 16'd3, "u_1x3");
      run_op(8'd5, 8'd2, 1'b0, 16'd10, "u_5x2");
      run_op(8'd0, 8'd6, 1'b0, 16'd0, "u_0x6");
      run_op(8'd3, 8'd7, 1'b0, 16'd21, "u_3x7");
      run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255x255");
      run_op(8'h80, 8'h02, 1'b0, 16'h0100, "u_80x02");
      run_op(8'hFF, 8'h7F, 1'b1, 16'hFF81, "s_m1x127");
      run_op(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_x_min");
      run_op(8'hFD, 8'h00, 1'b1, 16'h0000, "s_m3x0");

      // Start pulsed mid-calculation must be ignored.
      @(negedge clk);
      a = 8'd12; b = 8'd11; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1; nbusy = 0;
      while (!done && k < 40) begin
         if (busy) nbusy++;
         if (k == 3) begin a = 8'd200; b = 8'd199; start = 1'b1; end
         else start = 1'b0;
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk("ignore_start_p", 64'(p), 64'd132);
      chk("ignore_start_busy_cycles", 64'(nbusy), 64'd8);

      // Reset during calculation abandons the operation.
      @(negedge clk);
      a = 8'd9; b = 8'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_p", 64'(p), 64'd0);
      run_op(8'd6, 8'd7, 1'b0, 16'd42, "after_abort");

      // Start held high: back-to-back results every W+2 cycles.
      @(negedge clk);
      a = 8'd4; b = 8'd4; signed_mode = 1'b0; start = 1'b1;
      k = 0; ndone = 0; last_d = 0;
      while (ndone < 3 && k < 60) begin
         @(negedge clk);
         k++;
         if (done) begin
            if (ndone > 0) chk("b2b_spacing", 64'(k - last_d), 64'd10);
            last_d = k;
            ndone++;
         end
      end
      start = 1'b0;
      chk("b2b_count", 64'(ndone), 64'd3);
      repeat (3) @(negedge clk);

      // Random traffic including stray starts, operand churn and occasional reset.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         signed_mode = 1'($urandom);
         case ($urandom_range(0, 3))
            0: a = 8'h80;
            1: a = 8'hFF;
            default: a = 8'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: b = 8'h80;
            1: b = 8'h00;
            default: b = 8'($urandom);
         endcase
         rst = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      repeat (12) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
